// File: rtl/seg7_scan_driver_if.sv
// Display bus for seg7_scan_driver: digit data and strobes in, scanned segment
// and digit-enable drive out. The master is the data source and the slave is the driver.
interface seg7_scan_driver_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] bcd_in;
    logic [DIGITS-1:0]   dp_in;
    logic                load;
    logic                blank_lz;
    logic [6:0]          seg;
    logic                dp;
    logic [DIGITS-1:0]   an;
    logic                frame_done;
    logic                pending;

    modport master (
        output bcd_in, dp_in, load, blank_lz,
        input  seg, dp, an, frame_done, pending
    );

    modport slave (
        input  bcd_in, dp_in, load, blank_lz,
        output seg, dp, an, frame_done, pending
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed multi-digit seven-segment driver. It double-buffers BCD digits,
// swaps the buffers only at frame boundaries, and blanks the enables during the guard period.
module seg7_scan_driver #(
    parameter int DIGITS     = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int GUARD      = 2,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input logic               clk,
    input logic               rst_n,
    seg7_scan_driver_if.slave bus
);

    localparam int CNTW = $clog2(SCAN_DIV);
    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNTW-1:0]   CNT_LAST  = CNTW'(SCAN_DIV - 1);
    localparam logic [CNTW-1:0]   GUARD_CNT = CNTW'(GUARD);
    localparam logic [IDXW-1:0]   IDX_LAST  = IDXW'(DIGITS - 1);
    localparam logic [6:0]        SEG_OFF   = {7{ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] AN_OFF    = {DIGITS{ACTIVE_LOW}};

    logic [CNTW-1:0]     cnt_q, cnt_d;
    logic [IDXW-1:0]     idx_q, idx_d;
    logic [4*DIGITS-1:0] shadowBcd_q, shadowBcd_d;
    logic [DIGITS-1:0]   shadowDp_q, shadowDp_d;
    logic [4*DIGITS-1:0] activeBcd_q, activeBcd_d;
    logic [DIGITS-1:0]   activeDp_q, activeDp_d;
    logic                pending_q, pending_d;
    logic                frameStart_q;
    logic                frameDone_q;
    logic [6:0]          seg_q;
    logic                dp_q;
    logic [DIGITS-1:0]   an_q;

    logic                boundary;
    logic                inGuard;
    logic [3:0]          curCode;
    logic                curDp;
    logic                curBlank;
    logic [DIGITS-1:0]   anNext;
    logic [DIGITS-1:0]   lzBlank;
    logic                allZero;
    logic [6:0]          segNext;
    logic                dpNext;

    function automatic logic [6:0] decodeBcd(input logic [3:0] code);
        logic [6:0] pattern;
        case (code)
            4'd0:    pattern = 7'b1111110;
            4'd1:    pattern = 7'b0110000;
            4'd2:    pattern = 7'b1101101;
            4'd3:    pattern = 7'b1111001;
            4'd4:    pattern = 7'b0110011;
            4'd5:    pattern = 7'b1011011;
            4'd6:    pattern = 7'b1011111;
            4'd7:    pattern = 7'b1110000;
            4'd8:    pattern = 7'b1111111;
            4'd9:    pattern = 7'b1111011;
            default: pattern = 7'b0000001;
        endcase
        return pattern;
    endfunction

    assign boundary = (idx_q == IDX_LAST) && (cnt_q == CNT_LAST);
    assign inGuard  = (cnt_q < GUARD_CNT);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // A load that lands on the boundary goes straight to the active buffer,
    // so it never has to wait a whole extra frame.
    always_comb begin
        shadowBcd_d = shadowBcd_q;
        shadowDp_d  = shadowDp_q;
        activeBcd_d = activeBcd_q;
        activeDp_d  = activeDp_q;
        pending_d   = pending_q;
        if (bus.load) begin
            shadowBcd_d = bus.bcd_in;
            shadowDp_d  = bus.dp_in;
        end
        if (boundary) begin
            activeBcd_d = bus.load ? bus.bcd_in : shadowBcd_q;
            activeDp_d  = bus.load ? bus.dp_in  : shadowDp_q;
            pending_d   = 1'b0;
        end else if (bus.load) begin
            pending_d   = 1'b1;
        end
    end

    always_comb begin
        curCode = 4'd0;
        curDp   = 1'b0;
        anNext  = '0;
        lzBlank = '0;
        allZero = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            allZero = 1'b1;
            for (int j = i; j < DIGITS; j++) begin
                if (activeBcd_q[4*j +: 4] != 4'd0) begin
                    allZero = 1'b0;
                end
            end
            lzBlank[i] = allZero && (i != 0);
            if (idx_q == IDXW'(i)) begin
                curCode   = activeBcd_q[4*i +: 4];
                curDp     = activeDp_q[i];
                anNext[i] = 1'b1;
            end
        end
    end

    assign curBlank = bus.blank_lz && |(lzBlank & anNext);

    always_comb begin
        segNext = curBlank ? 7'b0000000 : decodeBcd(curCode);
        dpNext  = curDp;
        if (inGuard) begin
            segNext = 7'b0000000;
            dpNext  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            frameStart_q <= 1'b0;
            frameDone_q  <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            frameStart_q <= boundary;
            frameDone_q  <= frameStart_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadowBcd_q <= '0;
            shadowDp_q  <= '0;
            activeBcd_q <= '0;
            activeDp_q  <= '0;
            pending_q   <= 1'b0;
        end else begin
            shadowBcd_q <= shadowBcd_d;
            shadowDp_q  <= shadowDp_d;
            activeBcd_q <= activeBcd_d;
            activeDp_q  <= activeDp_d;
            pending_q   <= pending_d;
        end
    end

    // Polarity is folded in before the flops so reset lands on the inactive level directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= SEG_OFF;
            dp_q  <= ACTIVE_LOW;
            an_q  <= AN_OFF;
        end else begin
            seg_q <= segNext ^ SEG_OFF;
            dp_q  <= dpNext ^ ACTIVE_LOW;
            an_q  <= (inGuard ? '0 : anNext) ^ AN_OFF;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.an         = an_q;
    assign bus.frame_done = frameDone_q;
    assign bus.pending    = pending_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: scan timing, decode, tear-free loads, blanking,
// polarity and asynchronous reset, with an active-high and an active-low instance side by side.
module tb_seg7_scan_driver;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 8;
    localparam int GUARD    = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks  = 0;
    int errors  = 0;
    int relEdge = 0;

    typedef struct {
        int         edgeNum;
        logic [3:0] an;
        logic [6:0] seg;
        logic       fd;
    } scanVec_t;

    typedef struct {
        logic [3:0] code;
        logic [6:0] seg;
    } decodeVec_t;

    scanVec_t   scanTab[16];
    decodeVec_t decodeTab[16];

    always #5 clk = ~clk;

    seg7_scan_driver_if #(.DIGITS(DIGITS)) busHi();
    seg7_scan_driver_if #(.DIGITS(DIGITS)) busLo();

    assign busLo.bcd_in   = busHi.bcd_in;
    assign busLo.dp_in    = busHi.dp_in;
    assign busLo.load     = busHi.load;
    assign busLo.blank_lz = busHi.blank_lz;

    seg7_scan_driver #(
        .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .GUARD(GUARD), .ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(busHi)
    );

    seg7_scan_driver #(
        .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .GUARD(GUARD), .ACTIVE_LOW(1'b1)
    ) dutLow (
        .clk(clk), .rst_n(rst_n), .bus(busLo)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        relEdge++;
    endtask

    task automatic tickTo(input int n);
        while (relEdge < n) tick();
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] bcd, input logic [3:0] dpv);
        busHi.bcd_in = bcd;
        busHi.dp_in  = dpv;
        busHi.load   = 1'b1;
        tick();
        busHi.load   = 1'b0;
    endtask

    // Leaves the bench on the sample point where frame_done is high (relEdge = 1).
    task automatic waitFrame();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (busHi.frame_done !== 1'b1 && n < 100);
        if (busHi.frame_done !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL frame_done timeout: got %b expected 1", busHi.frame_done);
        end
        relEdge = 1;
    endtask

    task automatic checkDigits(input string name, input logic [27:0] exp);
        for (int d = 0; d < DIGITS; d++) begin
            tickTo(8*d + 4);
            checkOutput($sformatf("%s an d%0d", name, d), 32'(busHi.an), 32'(4'b0001 << d));
            checkOutput($sformatf("%s seg d%0d", name, d), 32'(busHi.seg), 32'(exp[7*d +: 7]));
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        scanTab[0]  = '{1,  4'b0000, 7'b0000000, 1'b0};
        scanTab[1]  = '{2,  4'b0000, 7'b0000000, 1'b0};
        scanTab[2]  = '{3,  4'b0001, 7'b1111110, 1'b0};
        scanTab[3]  = '{8,  4'b0001, 7'b1111110, 1'b0};
        scanTab[4]  = '{9,  4'b0000, 7'b0000000, 1'b0};
        scanTab[5]  = '{10, 4'b0000, 7'b0000000, 1'b0};
        scanTab[6]  = '{11, 4'b0010, 7'b1111110, 1'b0};
        scanTab[7]  = '{16, 4'b0010, 7'b1111110, 1'b0};
        scanTab[8]  = '{17, 4'b0000, 7'b0000000, 1'b0};
        scanTab[9]  = '{19, 4'b0100, 7'b1111110, 1'b0};
        scanTab[10] = '{27, 4'b1000, 7'b1111110, 1'b0};
        scanTab[11] = '{32, 4'b1000, 7'b1111110, 1'b0};
        scanTab[12] = '{33, 4'b0000, 7'b0000000, 1'b1};
        scanTab[13] = '{34, 4'b0000, 7'b0000000, 1'b0};
        scanTab[14] = '{64, 4'b1000, 7'b1111110, 1'b0};
        scanTab[15] = '{65, 4'b0000, 7'b0000000, 1'b1};

        decodeTab[0]  = '{4'd0,  7'b1111110};
        decodeTab[1]  = '{4'd1,  7'b0110000};
        decodeTab[2]  = '{4'd2,  7'b1101101};
        decodeTab[3]  = '{4'd3,  7'b1111001};
        decodeTab[4]  = '{4'd4,  7'b0110011};
        decodeTab[5]  = '{4'd5,  7'b1011011};
        decodeTab[6]  = '{4'd6,  7'b1011111};
        decodeTab[7]  = '{4'd7,  7'b1110000};
        decodeTab[8]  = '{4'd8,  7'b1111111};
        decodeTab[9]  = '{4'd9,  7'b1111011};
        decodeTab[10] = '{4'd10, 7'b0000001};
        decodeTab[11] = '{4'd11, 7'b0000001};
        decodeTab[12] = '{4'd12, 7'b0000001};
        decodeTab[13] = '{4'd13, 7'b0000001};
        decodeTab[14] = '{4'd14, 7'b0000001};
        decodeTab[15] = '{4'd15, 7'b0000001};

        busHi.bcd_in   = '0;
        busHi.dp_in    = '0;
        busHi.load     = 1'b0;
        busHi.blank_lz = 1'b0;

        // Reset state of both polarities.
        repeat (3) tick();
        checkOutput("reset an",         32'(busHi.an),         32'(4'b0000));
        checkOutput("reset seg",        32'(busHi.seg),        32'(7'b0000000));
        checkOutput("reset dp",         32'(busHi.dp),         32'(1'b0));
        checkOutput("reset frame_done", 32'(busHi.frame_done), 32'(1'b0));
        checkOutput("reset pending",    32'(busHi.pending),    32'(1'b0));
        checkOutput("reset low an",     32'(busLo.an),         32'(4'b1111));
        checkOutput("reset low seg",    32'(busLo.seg),        32'(7'b1111111));
        checkOutput("reset low dp",     32'(busLo.dp),         32'(1'b1));

        // Scan pattern, counting release edges from 1.
        rst_n   = 1'b1;
        relEdge = 0;
        for (int i = 0; i < 16; i++) begin
            tickTo(scanTab[i].edgeNum);
            checkOutput($sformatf("scan an e%0d", scanTab[i].edgeNum), 32'(busHi.an), 32'(scanTab[i].an));
            checkOutput($sformatf("scan seg e%0d", scanTab[i].edgeNum), 32'(busHi.seg), 32'(scanTab[i].seg));
            checkOutput($sformatf("scan fd e%0d", scanTab[i].edgeNum), 32'(busHi.frame_done), 32'(scanTab[i].fd));
        end

        // Decode sweep on digit 0.
        for (int i = 0; i < 16; i++) begin
            applyStimulus({12'h000, decodeTab[i].code}, 4'b0000);
            waitFrame();
            tickTo(4);
            checkOutput($sformatf("decode an %0d", decodeTab[i].code), 32'(busHi.an), 32'(4'b0001));
            checkOutput($sformatf("decode seg %0d", decodeTab[i].code), 32'(busHi.seg), 32'(decodeTab[i].seg));
        end

        // Mid-frame load stays hidden until the boundary.
        waitFrame();
        tickTo(5);
        applyStimulus(16'h1234, 4'b0000);
        checkOutput("tear pending set", 32'(busHi.pending), 32'(1'b1));
        checkOutput("tear old seg d0",  32'(busHi.seg),     32'(7'b0000001));
        tickTo(12);
        checkOutput("tear old seg d1",  32'(busHi.seg),     32'(7'b1111110));
        checkOutput("tear pending held", 32'(busHi.pending), 32'(1'b1));
        waitFrame();
        checkOutput("tear pending clear", 32'(busHi.pending), 32'(1'b0));
        checkDigits("tear new", {7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011});

        // Load exactly on the boundary edge.
        tickTo(31);
        busHi.bcd_in = 16'h5678;
        busHi.load   = 1'b1;
        tick();
        busHi.load   = 1'b0;
        checkOutput("boundary pending", 32'(busHi.pending), 32'(1'b0));
        tick();
        checkOutput("boundary fd",       32'(busHi.frame_done), 32'(1'b1));
        checkOutput("boundary pending2", 32'(busHi.pending),    32'(1'b0));
        relEdge = 1;
        checkDigits("boundary", {7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111});

        // Leading-zero blanking.
        busHi.blank_lz = 1'b1;
        applyStimulus(16'h0050, 4'b0000);
        waitFrame();
        checkDigits("lz 0050", {7'b0000000, 7'b0000000, 7'b1011011, 7'b1111110});
        applyStimulus(16'h0000, 4'b0000);
        waitFrame();
        checkDigits("lz 0000", {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110});
        busHi.blank_lz = 1'b0;
        waitFrame();
        checkDigits("lz off", {7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110});

        // Active-low polarity and decimal points.
        applyStimulus(16'h8888, 4'b0101);
        waitFrame();
        checkOutput("pol guard an",  32'(busLo.an),  32'(4'b1111));
        checkOutput("pol guard seg", 32'(busLo.seg), 32'(7'b1111111));
        checkOutput("pol guard dp",  32'(busLo.dp),  32'(1'b1));
        tickTo(4);
        checkOutput("pol d0 an",     32'(busLo.an),  32'(4'b1110));
        checkOutput("pol d0 dp",     32'(busLo.dp),  32'(1'b0));
        checkOutput("pol d0 seg",    32'(busLo.seg), 32'(7'b0000000));
        checkOutput("pol d0 hi dp",  32'(busHi.dp),  32'(1'b1));
        tickTo(9);
        checkOutput("pol guard2 an", 32'(busLo.an),  32'(4'b1111));
        checkOutput("pol guard2 dp", 32'(busLo.dp),  32'(1'b1));
        tickTo(12);
        checkOutput("pol d1 an",     32'(busLo.an),  32'(4'b1101));
        checkOutput("pol d1 dp",     32'(busLo.dp),  32'(1'b1));

        // Asynchronous reset with an update pending.
        applyStimulus(16'h9999, 4'b0000);
        checkOutput("areset pending before", 32'(busHi.pending), 32'(1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("areset an",      32'(busHi.an),         32'(4'b0000));
        checkOutput("areset seg",     32'(busHi.seg),        32'(7'b0000000));
        checkOutput("areset pending", 32'(busHi.pending),    32'(1'b0));
        checkOutput("areset low an",  32'(busLo.an),         32'(4'b1111));
        checkOutput("areset low seg", 32'(busLo.seg),        32'(7'b1111111));
        tick();
        rst_n   = 1'b1;
        relEdge = 0;
        tick();
        checkOutput("areset release pending", 32'(busHi.pending), 32'(1'b0));
        waitFrame();
        checkOutput("areset frame pending", 32'(busHi.pending), 32'(1'b0));
        checkDigits("areset zeros", {7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110});
        waitFrame();
        tickTo(20);
        checkOutput("areset d2 dp",     32'(busHi.dp), 32'(1'b0));
        checkOutput("areset d2 low dp", 32'(busLo.dp), 32'(1'b1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
